// File: rtl/sipo_stream_pkg.sv
// Shared defaults and mode encodings for the coefficient SIPO gatherer.
package sipo_stream_pkg;

   localparam int unsigned SIPO_IWID_DEF  = 12;
   localparam int unsigned SIPO_DEPTH_DEF = 6;
   localparam int unsigned SIPO_OCNT_DEF  = 4;

   typedef enum logic {
      SIPO_SLIDE = 1'b0,
      SIPO_BLOCK = 1'b1
   } sipo_mode_e;

   function automatic int unsigned sipo_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sipo_stream_if.sv
// Input/output stream bundle of the SIPO gatherer.
// Handshake: a word moves on a rising clk edge when vld and rdy are both high; vld/data hold until then.
interface sipo_stream_if
   import sipo_stream_pkg::*;
#(
   parameter int IWID = SIPO_IWID_DEF,
   parameter int OCNT = SIPO_OCNT_DEF
);

   logic                 di_vld;
   logic [IWID-1:0]      di;
   logic                 di_rdy;
   logic                 dout_vld;
   logic [IWID*OCNT-1:0] dout;
   logic                 dout_rdy;

   modport master (
      output di_vld, di, dout_rdy,
      input  di_rdy, dout_vld, dout
   );

   modport slave (
      input  di_vld, di, dout_rdy,
      output di_rdy, dout_vld, dout
   );

endinterface

// File: rtl/sipo_stream_shreg.sv
// Enable-driven shift chain; stage 0 takes the new word, all stages exposed flat.
module sipo_shreg #(
   parameter int IWID  = 12,
   parameter int DEPTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic [IWID-1:0]       d_i,
   output logic [IWID*DEPTH-1:0] stages_o
);

   logic [IWID-1:0] stage_q [DEPTH];
   logic [IWID-1:0] stage_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i];
      end
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = '0;
         end
      end else if (en_i) begin
         stage_d[0] = d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   always_comb begin
      stages_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         stages_o[i*IWID +: IWID] = stage_q[i];
      end
   end

endmodule

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out coefficient gatherer: sliding or block windows of the oldest OCNT words.
module sipo_stream
   import sipo_stream_pkg::*;
#(
   parameter int IWID  = SIPO_IWID_DEF,
   parameter int DEPTH = SIPO_DEPTH_DEF,
   parameter int OCNT  = SIPO_OCNT_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         mode,
   sipo_stream_if.slave                 bus,
   output logic [$clog2(DEPTH+1)-1:0]   dbg_cnt_o
);

   localparam int CW = sipo_cnt_w(DEPTH);
   localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_REFILL = CW'(DEPTH - OCNT);

   if (DEPTH < 2 || OCNT < 1 || OCNT > DEPTH) begin : g_bad_cfg
      $error("sipo_stream: need DEPTH >= 2 and 1 <= OCNT <= DEPTH");
   end

   logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
   logic                  vld_q, vld_d;
   logic                  acc;
   logic [IWID*DEPTH-1:0] stages;

   // A stalled output freezes the window so dout stays stable until taken.
   assign bus.di_rdy = !vld_q | bus.dout_rdy;
   assign acc        = bus.di_vld & bus.di_rdy & !clr;
   assign cnt_inc    = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + 1'b1;

   always_comb begin
      cnt_d = cnt_q;
      vld_d = vld_q;
      if (vld_q & bus.dout_rdy) begin
         vld_d = 1'b0;
      end
      if (clr) begin
         cnt_d = '0;
         vld_d = 1'b0;
      end else if (acc) begin
         if (cnt_inc == CNT_FULL) begin
            vld_d = 1'b1;
            // Block mode keeps the newest DEPTH-OCNT words as the start of the next group.
            cnt_d = (mode == SIPO_BLOCK) ? CNT_REFILL : CNT_FULL;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   sipo_shreg #(
      .IWID  (IWID),
      .DEPTH (DEPTH)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr),
      .en_i     (acc),
      .d_i      (bus.di),
      .stages_o (stages)
   );

   always_comb begin
      bus.dout = '0;
      for (int k = 0; k < OCNT; k++) begin
         bus.dout[k*IWID +: IWID] = stages[(DEPTH-1-k)*IWID +: IWID];
      end
   end

   assign bus.dout_vld = vld_q;
   assign dbg_cnt_o    = cnt_q;

endmodule

// File: doc/sipo_stream.md
# sipo_stream

Parametrised serial-in/parallel-out coefficient gatherer, the successor of the fixed 6-deep, 4-lane SIPO in the coefficient datapath. It accepts one IWID-bit coefficient per handshake and presents the oldest OCNT words of a DEPTH-deep window as one parallel word. Two modes are provided: sliding (overlapping windows, one output per input once full) and block (non-overlapping groups of OCNT). Valid/ready handshakes on both sides give full backpressure.

## Interface
- IWID, 12, coefficient width in bits.
- DEPTH, 6, shift-window depth in words; DEPTH >= 2.
- OCNT, 4, output lanes; 1 <= OCNT <= DEPTH.
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; priority over all other activity.
- mode  input  1  0 = sliding, 1 = block; sampled on each accept.
- di_vld  input  1  input word valid.
- di  input  IWID  input coefficient.
- di_rdy  output  1  input ready.
- dout_vld  output  1  parallel output valid (registered).
- dout  output  IWID*OCNT  parallel output; lane k (bits [k*IWID +: IWID]) = stage DEPTH-1-k.
- dout_rdy  input  1  downstream ready.

## Operation
- Stage registers s[0..DEPTH-1], IWID bits each. s[0] is the newest word and s[DEPTH-1] the oldest.
- Accept: acc = di_vld & di_rdy & !clr. On acc, s[0] <= di and s[i] <= s[i-1]. With no acc, stages hold.
- di_rdy = !dout_vld | dout_rdy (combinational). A stalled output blocks shifting, so dout stays stable while dout_vld & !dout_rdy.
- dout is driven directly from the stages (no extra register). Lane 0 carries the oldest word.
- Fill counter cnt, width $clog2(DEPTH+1), range 0..DEPTH. On acc, cn = min(cnt+1, DEPTH).
- Sliding mode (mode=0):
  - On acc: cnt <= cn.
  - On acc with cn == DEPTH: dout_vld <= 1.
  - Once the window is full, every accept produces one overlapping window.
- Block mode (mode=1):
  - On acc with cn == DEPTH: cnt <= DEPTH-OCNT and dout_vld <= 1.
  - Otherwise on acc: cnt <= cn.
  - Successive outputs are consecutive, non-overlapping OCNT-word groups.
- dout_vld clear: dout_vld <= 0 when dout_vld & dout_rdy and the same cycle does not set it. Set has priority over clear.
- Mode changes are intended only while cnt == 0. Otherwise behaviour follows the rules above, with no special casing.
- clr: all stages <= 0, cnt <= 0, dout_vld <= 0. A word presented with clr is dropped.
- Reset (rst low, asynchronous): all stages 0, cnt 0, dout_vld 0. Therefore dout = 0 and di_rdy = 1.

## Timing
- One cycle from the accept of the completing word to dout_vld high.
- The transfer cycle (dout_vld & dout_rdy) may also accept a new word. dout shows the pre-shift window in that cycle.
- Sliding mode, no stalls: steady throughput of 1 output per input. First output DEPTH accepts after reset/clr.
- Block mode, no stalls: 1 output per OCNT inputs. First output after DEPTH accepts.
- Stall boundary: dout_vld=1 and dout_rdy=0 force di_rdy=0. cnt, stages and dout are frozen until dout_rdy rises.
- Reset mid-stream discards all partial data. The first output after reset requires a full DEPTH refill.

## Structure
- Shared header/package: default IWID (Kyber coefficient width, 12) and the mode encodings SIPO_SLIDE=0 and SIPO_BLOCK=1.
- Sub-module sipo_shreg: a parametrised (IWID, DEPTH) enable-shift chain with async active-low reset and sync clear, exposing all stages flat.
- Counter, valid and handshake logic live in sipo_stream.
- Elaboration-time check: OCNT <= DEPTH and DEPTH >= 2.

## Test plan
- Reset, then sliding mode with defaults; accept 1..7 back-to-back with dout_rdy=1.
  - dout_vld first high the cycle after word 6, lanes 0..3 = 1,2,3,4.
  - Next cycle lanes = 2,3,4,5.
- Block mode, defaults; accept 1..10 back-to-back.
  - Outputs {1,2,3,4} one cycle after word 6, then {5,6,7,8} one cycle after word 10.
  - dout_vld is high for exactly 1 cycle each time.
- Backpressure: sliding mode full, dout_rdy=0 for 3 cycles with di_vld=1.
  - di_rdy=0 and dout unchanged for those cycles.
  - When dout_rdy rises, the pending word is accepted in that cycle with no loss or duplication.
- clr asserted with di_vld=1 after 4 accepts.
  - cnt=0, dout=0, dout_vld=0.
  - The next output requires 6 new accepts.
- Async reset pulse mid-cycle while dout_vld=1.
  - Outputs go to 0 immediately; di_rdy=1.
- Parameter sweep DEPTH=8, OCNT=8, IWID=16, block mode.
  - Accept 0x0001..0x0010; outputs are {1..8} and then {9..16}.
